data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have port CLK, input, 1, the single clock; all state is updated on its rising edge.
REQ-002 SHALL have port RSTn, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port D_MEM_CSN, input, 1, core chip select, active-low.
REQ-004 SHALL have port D_MEM_ADDR, input, 12, core byte address; the word index is bits [11:2].
REQ-005 SHALL have port D_MEM_WEN, input, 1, core write enable, active-low.
REQ-006 SHALL have port D_MEM_BE, input, 4, core byte enables; BE[i] selects bits [8i+7:8i].
REQ-007 SHALL have port D_MEM_DOUT, input, 32, core write data.
REQ-008 SHALL have port D_MEM_DI, output, 32, read data returned to the core.
REQ-009 SHALL have loader ports LD_START (input, 1), LD_BASE (input, 10, start word index), LD_VALID (input, 1), LD_DATA (input, 32), LD_LAST (input, 1), LD_READY (output, 1), LD_BUSY (output, 1) and LD_DONE (output, 1).
REQ-010 SHALL have ports ERR_MISALIGN (output, 1, sticky error flag) and ERR_CLR (input, 1, clears the flag).
REQ-011 SHALL have ports RD_CNT (output, 16) and WR_CNT (output, 16) for access statistics.

Function
REQ-012 SHALL hold storage as 1024 x 32-bit words (4 KB).
REQ-013 SHALL drive D_MEM_DI combinationally with mem[ADDR[11:2]] when CSN=0 and WEN=1, and with 0 otherwise.
REQ-014 SHALL write, on a clock edge where CSN=0, WEN=0 and LD_BUSY=0, only the bytes of mem[ADDR[11:2]] whose BE bit is 1; BE=0000 leaves the word unchanged.
REQ-015 SHALL return pre-write data on a same-cycle read of a word being written; the new data is visible from the next cycle.
REQ-016 SHALL set ERR_MISALIGN on the clock edge following any cycle with CSN=0 and ADDR[1:0]!=0, while still performing the access on word ADDR[11:2].
REQ-017 SHALL hold ERR_MISALIGN set until a cycle with ERR_CLR=1; if a set condition and ERR_CLR occur in the same cycle, the flag SHALL end set.
REQ-018 SHALL implement the loader as a three-state FSM: IDLE, LOAD, DONE.
REQ-019 SHALL, in IDLE, drive LD_READY=0, LD_BUSY=0 and LD_DONE=0; LD_START=1 SHALL move the FSM to LOAD and set ptr=LD_BASE.
REQ-020 SHALL, in LOAD, drive LD_READY=1 and LD_BUSY=1; on each beat with LD_VALID=1, mem[ptr] SHALL be written with LD_DATA (all bytes) and ptr SHALL increment, wrapping from 1023 to 0.
REQ-021 SHALL move LOAD to DONE on an accepted beat with LD_LAST=1.
REQ-022 SHALL, in DONE, drive LD_DONE=1 and LD_BUSY=0 for exactly one cycle, then return to IDLE.
REQ-023 SHALL ignore LD_START outside IDLE.
REQ-024 SHALL silently drop core writes while LD_BUSY=1; core reads SHALL still be served during that time.
REQ-025 SHALL leave LD_VALID without effect while the FSM is not in LOAD.

Reset
REQ-026 SHALL, when RSTn=0, immediately (asynchronously) force the FSM to IDLE, ptr=0, ERR_MISALIGN=0, RD_CNT=0 and WR_CNT=0, so that LD_READY, LD_BUSY and LD_DONE read 0.
REQ-027 SHALL NOT alter array contents on reset, and a reset during LOAD SHALL abort the load, keeping all words already written.
REQ-028 SHALL follow REQ-013 for D_MEM_DI during reset, since D_MEM_DI has no stored state.

Configuration
REQ-029 SHALL, with macro DATA_MEM_RESPONDER_STATS_EN defined, increment RD_CNT each cycle with CSN=0 and WEN=1.
REQ-030 SHALL, with that macro defined, increment WR_CNT each cycle in which a core write is performed per REQ-014.
REQ-031 SHALL saturate both counters at 16'hFFFF.
REQ-032 SHALL, with the macro undefined, keep RD_CNT and WR_CNT present and tied to 0, with no counter logic.

Verification
REQ-033 SHALL cover: write 0xDEADBEEF to addr 0x010 with BE=1111, then write 0x000000AA with BE=0001 -> a read of 0x010 returns 0xDEADBEAA.
REQ-034 SHALL cover: read of 0x013 with CSN=0 -> ERR_MISALIGN=1 on the next edge, data of word 4 returned; pulse ERR_CLR -> flag returns to 0.
REQ-035 SHALL cover: LD_START with LD_BASE=1022, then 3 beats 0x1, 0x2, 0x3 with LAST on the third -> words 1022, 1023 and 0 hold 1, 2 and 3; LD_DONE pulses exactly one cycle.
REQ-036 SHALL cover: a core write to 0x040 while LD_BUSY=1 -> word 16 unchanged and WR_CNT unchanged.
REQ-037 SHALL cover: RSTn low after 2 load beats -> FSM in IDLE, the 2 written words retained, LD_READY=0.
REQ-038 SHALL cover, with DATA_MEM_RESPONDER_STATS_EN defined: 70000 read cycles -> RD_CNT=0xFFFF.

Source files
------------

// File: rtl/data_mem_responder.sv
// Core-facing 1024x32 data memory with a streaming bulk loader, a sticky misalignment flag and access counters.
// Optional access counters are enabled by defining DATA_MEM_RESPONDER_STATS_EN.
module data_mem_responder (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        D_MEM_CSN,
  input  logic [11:0] D_MEM_ADDR,
  input  logic        D_MEM_WEN,
  input  logic [3:0]  D_MEM_BE,
  input  logic [31:0] D_MEM_DOUT,
  output logic [31:0] D_MEM_DI,
  input  logic        LD_START,
  input  logic [9:0]  LD_BASE,
  input  logic        LD_VALID,
  input  logic [31:0] LD_DATA,
  input  logic        LD_LAST,
  output logic        LD_READY,
  output logic        LD_BUSY,
  output logic        LD_DONE,
  output logic        ERR_MISALIGN,
  input  logic        ERR_CLR,
  output logic [15:0] RD_CNT,
  output logic [15:0] WR_CNT
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } ld_state_t;

  ld_state_t   state_r;
  ld_state_t   state_s;
  logic [9:0]  ptr_r;
  logic [9:0]  ptr_s;
  logic        err_r;
  logic        err_s;
  logic [31:0] mem_r [0:1023];

  logic [9:0]  word_idx_s;
  logic        core_rd_s;
  logic        core_wr_s;
  logic        ld_wr_s;
  logic        err_set_s;

  // Decode of core and loader access qualifiers.
  always_comb begin
    word_idx_s = D_MEM_ADDR[11:2];
    core_rd_s  = !D_MEM_CSN && D_MEM_WEN;
    core_wr_s  = !D_MEM_CSN && !D_MEM_WEN && (state_r != ST_LOAD);
    ld_wr_s    = (state_r == ST_LOAD) && LD_VALID;
    err_set_s  = !D_MEM_CSN && (D_MEM_ADDR[1:0] != 2'b00);
  end

  // Loader status outputs decoded from the state register.
  always_comb begin
    LD_READY = (state_r == ST_LOAD);
    LD_BUSY  = (state_r == ST_LOAD);
    LD_DONE  = (state_r == ST_DONE);
  end

  // Asynchronous read port; a write in the same cycle only lands at the edge.
  always_comb begin
    if (core_rd_s) begin
      D_MEM_DI = mem_r[word_idx_s];
    end else begin
      D_MEM_DI = 32'h0000_0000;
    end
  end

  // Storage array: deliberately outside the reset domain so an aborted load keeps its words.
  always_ff @(posedge CLK) begin
    if (ld_wr_s) begin
      mem_r[ptr_r] <= LD_DATA;
    end else if (core_wr_s) begin
      for (int i = 0; i < 4; i++) begin
        if (D_MEM_BE[i]) begin
          mem_r[word_idx_s][8*i +: 8] <= D_MEM_DOUT[8*i +: 8];
        end
      end
    end
  end

  // Loader next-state and write-pointer logic.
  always_comb begin
    state_s = state_r;
    ptr_s   = ptr_r;
    case (state_r)
      ST_IDLE: begin
        if (LD_START) begin
          state_s = ST_LOAD;
          ptr_s   = LD_BASE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (LD_VALID) begin
          ptr_s = ptr_r + 10'd1;
          if (LD_LAST) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_LOAD;
          end
        end else begin
          state_s = ST_LOAD;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
        ptr_s   = 10'd0;
      end
    endcase
  end

  // Loader state and pointer registers.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_r <= ST_IDLE;
      ptr_r   <= 10'd0;
    end else begin
      state_r <= state_s;
      ptr_r   <= ptr_s;
    end
  end

  // A new misalignment wins over a simultaneous clear.
  always_comb begin
    if (err_set_s) begin
      err_s = 1'b1;
    end else if (ERR_CLR) begin
      err_s = 1'b0;
    end else begin
      err_s = err_r;
    end
  end

  // Sticky misalignment flag register.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_s;
    end
  end

  assign ERR_MISALIGN = err_r;

`ifdef DATA_MEM_RESPONDER_STATS_EN
  logic [15:0] rd_cnt_r;
  logic [15:0] wr_cnt_r;

  // Saturating read/write access counters.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      rd_cnt_r <= 16'h0000;
      wr_cnt_r <= 16'h0000;
    end else begin
      if (core_rd_s && (rd_cnt_r != 16'hFFFF)) begin
        rd_cnt_r <= rd_cnt_r + 16'd1;
      end
      if (core_wr_s && (wr_cnt_r != 16'hFFFF)) begin
        wr_cnt_r <= wr_cnt_r + 16'd1;
      end
    end
  end

  assign RD_CNT = rd_cnt_r;
  assign WR_CNT = wr_cnt_r;
`else
  assign RD_CNT = 16'h0000;
  assign WR_CNT = 16'h0000;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: stimulus queues expectations, a negedge monitor checks them.
module tb_data_mem_responder;

  logic        CLK;
  logic        RSTn;
  logic        csn;
  logic [11:0] addr;
  logic        wen;
  logic [3:0]  be;
  logic [31:0] dout;
  logic [31:0] di;
  logic        ld_start;
  logic [9:0]  ld_base;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic        ld_busy;
  logic        ld_done;
  logic        err_misalign;
  logic        err_clr;
  logic [15:0] rd_cnt;
  logic [15:0] wr_cnt;

  data_mem_responder dut (
    .CLK(CLK), .RSTn(RSTn),
    .D_MEM_CSN(csn), .D_MEM_ADDR(addr), .D_MEM_WEN(wen), .D_MEM_BE(be),
    .D_MEM_DOUT(dout), .D_MEM_DI(di),
    .LD_START(ld_start), .LD_BASE(ld_base), .LD_VALID(ld_valid), .LD_DATA(ld_data),
    .LD_LAST(ld_last), .LD_READY(ld_ready), .LD_BUSY(ld_busy), .LD_DONE(ld_done),
    .ERR_MISALIGN(err_misalign), .ERR_CLR(err_clr),
    .RD_CNT(rd_cnt), .WR_CNT(wr_cnt)
  );

  localparam int K_DI = 0, K_ERR = 1, K_RDY = 2, K_BUSY = 3, K_DONE = 4, K_RD = 5, K_WR = 6;

  typedef struct {
    int          kind;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] rd_exp = 16'h0000;
  logic [15:0] wr_exp = 16'h0000;
  bit          loading = 1'b0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] observe(input int kind);
    case (kind)
      K_DI:    return di;
      K_ERR:   return {31'd0, err_misalign};
      K_RDY:   return {31'd0, ld_ready};
      K_BUSY:  return {31'd0, ld_busy};
      K_DONE:  return {31'd0, ld_done};
      K_RD:    return {16'd0, rd_cnt};
      K_WR:    return {16'd0, wr_cnt};
      default: return 32'hXXXX_XXXX;
    endcase
  endfunction

  // Monitor: drain every expectation queued for this cycle, away from the active edge.
  always @(negedge CLK) begin
    while (sb.size() > 0) begin
      exp_t e;
      logic [31:0] act;
      e = sb.pop_front();
      act = observe(e.kind);
      checks++;
      if (act !== e.val) begin
        errors++;
        $display("FAIL %s: got 0x%08h, expected 0x%08h", e.name, act, e.val);
      end
    end
  end

  task automatic chk(input int kind, input logic [31:0] val, input string name);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    e.name = name;
    sb.push_back(e);
  endtask

  // Advance one cycle, updating the counter model from the inputs seen at this edge.
  task automatic step();
`ifdef DATA_MEM_RESPONDER_STATS_EN
    if (RSTn) begin
      if (!csn && wen && rd_exp != 16'hFFFF) rd_exp = rd_exp + 16'd1;
      if (!csn && !wen && !loading && wr_exp != 16'hFFFF) wr_exp = wr_exp + 16'd1;
    end
`endif
    @(posedge CLK);
    #1;
  endtask

  task automatic set_idle();
    csn = 1'b1; wen = 1'b1; err_clr = 1'b0;
    ld_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [3:0] b, input logic [31:0] d);
    csn = 1'b0; wen = 1'b0; addr = a; be = b; dout = d;
    step();
    set_idle();
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string name);
    csn = 1'b0; wen = 1'b1; addr = a;
    chk(K_DI, exp, name);
    step();
    set_idle();
  endtask

  initial begin
    RSTn = 1'b0; addr = 12'h000; be = 4'h0; dout = 32'h0;
    ld_base = 10'd0; ld_data = 32'h0;
    set_idle();
    #2;
    chk(K_RDY, 32'd0, "rst_ready"); chk(K_BUSY, 32'd0, "rst_busy");
    chk(K_DONE, 32'd0, "rst_done"); chk(K_ERR, 32'd0, "rst_err");
    chk(K_RD, 32'd0, "rst_rdcnt"); chk(K_WR, 32'd0, "rst_wrcnt");
    chk(K_DI, 32'd0, "rst_di_idle");
    step(); step();
    RSTn = 1'b1;
    step();

    // Byte-enable merge, BE=0000 no-op, DI zero during a write and when deselected
    wr(12'h010, 4'hF, 32'hDEAD_BEEF);
    csn = 1'b0; wen = 1'b0; addr = 12'h010; be = 4'h1; dout = 32'h0000_00AA;
    chk(K_DI, 32'd0, "di_during_write");
    step(); set_idle();
    rd(12'h010, 32'hDEAD_BEAA, "be_merge");
    wr(12'h010, 4'h0, 32'hFFFF_FFFF);
    rd(12'h010, 32'hDEAD_BEAA, "be_none");
    addr = 12'h010;
    chk(K_DI, 32'd0, "di_deselected");
    step();

    // Misalignment: data of word 4, flag on next edge, sticky, clear, set-wins-over-clear
    rd(12'h013, 32'hDEAD_BEAA, "misalign_data");
    chk(K_ERR, 32'd1, "misalign_set");
    step();
    err_clr = 1'b1;
    chk(K_ERR, 32'd1, "misalign_sticky");
    step(); err_clr = 1'b0;
    chk(K_ERR, 32'd0, "misalign_cleared");
    step();
    csn = 1'b0; wen = 1'b1; addr = 12'h011; err_clr = 1'b1;
    step(); set_idle();
    chk(K_ERR, 32'd1, "set_beats_clr");
    err_clr = 1'b1;
    step(); err_clr = 1'b0;
    chk(K_ERR, 32'd0, "clr_again");
    chk(K_RD, {16'd0, rd_exp}, "rdcnt_mid");
    chk(K_WR, {16'd0, wr_exp}, "wrcnt_mid");
    step();

    // Wrapping load with a dropped core write, ignored LD_START, ignored LD_VALID in IDLE
    wr(12'h040, 4'hF, 32'h1111_1111);
    wr(12'h004, 4'hF, 32'h0000_0055);
    ld_start = 1'b1; ld_base = 10'd1022;
    chk(K_RDY, 32'd0, "idle_ready");
    step();
    ld_start = 1'b0; ld_valid = 1'b1; ld_data = 32'h1; loading = 1'b1;
    csn = 1'b0; wen = 1'b0; addr = 12'h040; be = 4'hF; dout = 32'hBAD0_BAD0;
    chk(K_RDY, 32'd1, "load_ready"); chk(K_BUSY, 32'd1, "load_busy"); chk(K_DONE, 32'd0, "load_done0");
    step();
    csn = 1'b1; wen = 1'b1; ld_data = 32'h2; ld_start = 1'b1; ld_base = 10'd5;
    step();
    ld_start = 1'b0; ld_data = 32'h3; ld_last = 1'b1;
    step();
    loading = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
    chk(K_DONE, 32'd1, "done_pulse"); chk(K_BUSY, 32'd0, "done_busy"); chk(K_RDY, 32'd0, "done_ready");
    step();
    chk(K_DONE, 32'd0, "done_one_cycle"); chk(K_WR, {16'd0, wr_exp}, "wrcnt_dropped");
    ld_valid = 1'b1; ld_data = 32'hFFFF_FFFF;
    step();
    ld_valid = 1'b0;
    rd(12'hFF8, 32'h1, "load_w1022");
    rd(12'hFFC, 32'h2, "load_w1023");
    rd(12'h000, 32'h3, "load_w0_wrap");
    rd(12'h040, 32'h1111_1111, "busy_write_dropped");
    rd(12'h004, 32'h0000_0055, "valid_in_idle_ignored");

    // Reset mid-load: abort to IDLE, keep written words, clear flag and counters
    csn = 1'b0; wen = 1'b1; addr = 12'h011;
    step(); set_idle();
    chk(K_ERR, 32'd1, "err_before_rst");
    ld_start = 1'b1; ld_base = 10'd100;
    step();
    ld_start = 1'b0; ld_valid = 1'b1; ld_data = 32'hA0;
    step();
    ld_data = 32'hA1;
    step();
    ld_valid = 1'b0;
    chk(K_BUSY, 32'd1, "busy_before_rst");
    step();
    RSTn = 1'b0; rd_exp = 16'h0000; wr_exp = 16'h0000;
    chk(K_RDY, 32'd0, "rst_load_ready"); chk(K_BUSY, 32'd0, "rst_load_busy");
    chk(K_ERR, 32'd0, "rst_load_err"); chk(K_RD, 32'd0, "rst_load_rdcnt");
    step();
    RSTn = 1'b1;
    step();
    chk(K_RDY, 32'd0, "after_rst_ready");
    rd(12'h190, 32'hA0, "kept_w100");
    rd(12'h194, 32'hA1, "kept_w101");

    // Read counter saturation
`ifdef DATA_MEM_RESPONDER_STATS_EN
    csn = 1'b0; wen = 1'b1; addr = 12'h000;
    repeat (70000) step();
    set_idle();
    chk(K_RD, 32'h0000_FFFF, "rdcnt_saturated");
`else
    chk(K_RD, {16'd0, rd_exp}, "rdcnt_tied");
`endif
    chk(K_WR, {16'd0, wr_exp}, "wrcnt_final");
    step();

    @(negedge CLK);
    #1;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
